// File: rtl/udma_hyper_evt_router_pkg.sv
// udma_hyper_evt_router_pkg: shared direction type, event slot indices and direction update rule
package udma_hyper_evt_router_pkg;
    typedef enum logic [1:0] {
        DIR_UNKNOWN = 2'd0,
        DIR_READ    = 2'd1,
        DIR_WRITE   = 2'd2
    } hyper_dir_e;
    localparam int EVT_RX     = 0;
    localparam int EVT_TX     = 1;
    localparam int EVT_EOT_RD = 2;
    localparam int EVT_EOT_WR = 3;
    localparam int EVT_PER_CH = 4;
    function automatic hyper_dir_e next_dir(hyper_dir_e cur, logic rx, logic tx);
        return (rx && !tx) ? DIR_READ : (tx && !rx) ? DIR_WRITE : cur;
    endfunction
endpackage

// File: rtl/udma_hyper_evt_rr_arb.sv
// udma_hyper_evt_rr_arb: combinational round-robin picker starting the search at ptr_i
// ports: req_i request vector, ptr_i first index to consider,
//        gnt_valid_o any request present, gnt_idx_o chosen index (0 when none)
module udma_hyper_evt_rr_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         gnt_valid_o,
    output logic [W-1:0] gnt_idx_o
);
    logic [W-1:0] j;
    // scan from the farthest offset down so the closest request to ptr_i wins last
    always_comb begin
        gnt_idx_o = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr_i) + i) % N);
            if (req_i[j]) gnt_idx_o = j;
        end
    end
    assign gnt_valid_o = |req_i;
endmodule

// File: rtl/udma_hyper_evt_router.sv
// udma_hyper_evt_router: per-channel HyperBus direction tracking, EOT classification and event serialization
// ports: sys_clk_i/rst_i clock and sync reset; ch_rx/tx/eot_evt_i per-channel input pulses;
//        evt_o registered slot pulses (ch*4+{rx,tx,eot_rd,eot_wr}); evt_valid_o/evt_id_o/evt_ready_i
//        serialized event handshake; dir_o direction per channel; ovf_o/unk_eot_o sticky flags; clr_i clears them
module udma_hyper_evt_router
    import udma_hyper_evt_router_pkg::*;
#(
    parameter int NB_CH     = 2,
    parameter int CNT_WIDTH = 4,
    parameter int EOT_SPLIT = 1
) (
    input  logic                                  sys_clk_i,
    input  logic                                  rst_i,
    input  logic [NB_CH-1:0]                      ch_rx_evt_i,
    input  logic [NB_CH-1:0]                      ch_tx_evt_i,
    input  logic [NB_CH-1:0]                      ch_eot_i,
    output logic [EVT_PER_CH*NB_CH-1:0]           evt_o,
    output logic                                  evt_valid_o,
    output logic [$clog2(EVT_PER_CH*NB_CH)-1:0]   evt_id_o,
    input  logic                                  evt_ready_i,
    output logic [2*NB_CH-1:0]                    dir_o,
    output logic [EVT_PER_CH*NB_CH-1:0]           ovf_o,
    output logic [NB_CH-1:0]                      unk_eot_o,
    input  logic                                  clr_i
);
    localparam int NS = EVT_PER_CH * NB_CH;
    localparam int IW = $clog2(NS);
    hyper_dir_e           dir_q [NB_CH];
    hyper_dir_e           dir_d [NB_CH];
    logic [NS-1:0]        evt_q, evt_d, ovf_q, ovf_d, ovf_set, dec, req;
    logic [NB_CH-1:0]     unk_q, unk_d, unk_set;
    logic [CNT_WIDTH-1:0] cnt_q [NS];
    logic [CNT_WIDTH-1:0] cnt_d [NS];
    logic                 valid_q, valid_d, hs, gnt_valid;
    logic [IW-1:0]        id_q, id_d, ptr_q, ptr_d, gnt_idx;
    // classification looks at the direction after this cycle's rx/tx update
    always_comb begin
        dir_d   = dir_q;
        evt_d   = '0;
        unk_set = '0;
        for (int c = 0; c < NB_CH; c++) begin
            dir_d[c] = next_dir(dir_q[c], ch_rx_evt_i[c], ch_tx_evt_i[c]);
            evt_d[c*EVT_PER_CH+EVT_RX]     = ch_rx_evt_i[c];
            evt_d[c*EVT_PER_CH+EVT_TX]     = ch_tx_evt_i[c];
            evt_d[c*EVT_PER_CH+EVT_EOT_RD] = ch_eot_i[c] && (dir_d[c] == DIR_READ ||
                                             (EOT_SPLIT == 0 && dir_d[c] == DIR_WRITE));
            evt_d[c*EVT_PER_CH+EVT_EOT_WR] = ch_eot_i[c] && EOT_SPLIT != 0 && dir_d[c] == DIR_WRITE;
            unk_set[c] = ch_eot_i[c] && dir_d[c] == DIR_UNKNOWN;
        end
    end
    assign hs = valid_q && evt_ready_i;
    // requests see the handshake decrement but not this cycle's increments, giving two-edge latency
    always_comb begin
        dec     = '0;
        req     = '0;
        ovf_set = '0;
        cnt_d   = cnt_q;
        for (int s = 0; s < NS; s++) begin
            dec[s]     = hs && id_q == IW'(s);
            req[s]     = (cnt_q[s] - CNT_WIDTH'(dec[s])) != '0;
            ovf_set[s] = evt_d[s] && !dec[s] && &cnt_q[s];
            cnt_d[s]   = ovf_set[s] ? cnt_q[s] : cnt_q[s] + CNT_WIDTH'(evt_d[s]) - CNT_WIDTH'(dec[s]);
        end
    end
    assign ptr_d   = hs ? (id_q == IW'(NS - 1) ? '0 : id_q + 1'b1) : ptr_q;
    assign valid_d = (valid_q && !evt_ready_i) ? 1'b1 : gnt_valid;
    assign id_d    = (valid_q && !evt_ready_i) ? id_q : gnt_idx;
    assign ovf_d   = (ovf_q & ~{NS{clr_i}}) | ovf_set;
    assign unk_d   = (unk_q & ~{NB_CH{clr_i}}) | unk_set;
    udma_hyper_evt_rr_arb #(.N(NS)) u_arb (
        .req_i      (req),
        .ptr_i      (ptr_d),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NB_CH; c++) dir_q[c] <= DIR_UNKNOWN;
            for (int s = 0; s < NS; s++) cnt_q[s] <= '0;
            evt_q   <= '0;
            ovf_q   <= '0;
            unk_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            ovf_q   <= ovf_d;
            unk_q   <= unk_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
    always_comb begin
        dir_o = '0;
        for (int c = 0; c < NB_CH; c++) dir_o[2*c +: 2] = dir_q[c];
    end
    assign evt_o       = evt_q;
    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign ovf_o       = ovf_q;
    assign unk_eot_o   = unk_q;
endmodule

// File: tb/tb_udma_hyper_evt_router.sv
// tb_udma_hyper_evt_router: vector table, directed corner cases and random traffic against a reference model
module tb_udma_hyper_evt_router;
    localparam int NB = 2;
    localparam int NS = 8;
    localparam int CMAX = 15;
    logic clk, rst, ready, clr;
    logic [NB-1:0] rx, tx, eot;
    logic [NS-1:0] evt_w [2];
    logic [NS-1:0] ovf_w [2];
    logic          valid_w [2];
    logic [2:0]    id_w [2];
    logic [3:0]    dir_w [2];
    logic [NB-1:0] unk_w [2];
    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    udma_hyper_evt_router #(.NB_CH(2), .CNT_WIDTH(4), .EOT_SPLIT(1)) dut (
        .sys_clk_i(clk), .rst_i(rst), .ch_rx_evt_i(rx), .ch_tx_evt_i(tx), .ch_eot_i(eot),
        .evt_o(evt_w[0]), .evt_valid_o(valid_w[0]), .evt_id_o(id_w[0]), .evt_ready_i(ready),
        .dir_o(dir_w[0]), .ovf_o(ovf_w[0]), .unk_eot_o(unk_w[0]), .clr_i(clr));
    udma_hyper_evt_router #(.NB_CH(2), .CNT_WIDTH(4), .EOT_SPLIT(0)) dut_ns (
        .sys_clk_i(clk), .rst_i(rst), .ch_rx_evt_i(rx), .ch_tx_evt_i(tx), .ch_eot_i(eot),
        .evt_o(evt_w[1]), .evt_valid_o(valid_w[1]), .evt_id_o(id_w[1]), .evt_ready_i(ready),
        .dir_o(dir_w[1]), .ovf_o(ovf_w[1]), .unk_eot_o(unk_w[1]), .clr_i(clr));
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // reference model: m=0 splits EOT into read/write, m=1 reports all EOT on the read slot
    int mdir [2][NB];
    int mcnt [2][NS];
    logic [NS-1:0] mevt [2], movf [2], mp;
    logic [NB-1:0] munk [2];
    logic mval [2];
    int mid [2], mptr [2];
    logic [3:0] mdv;
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int c = 0; c < NB; c++) mdir[m][c] = 0;
                for (int s = 0; s < NS; s++) mcnt[m][s] = 0;
                mevt[m] = 0; movf[m] = 0; munk[m] = 0; mval[m] = 0; mid[m] = 0; mptr[m] = 0;
            end else begin
                mp = 0;
                if (clr) begin movf[m] = 0; munk[m] = 0; end
                for (int c = 0; c < NB; c++) begin
                    if (rx[c] && !tx[c]) mdir[m][c] = 1;
                    else if (tx[c] && !rx[c]) mdir[m][c] = 2;
                    if (rx[c]) mp[c*4] = 1;
                    if (tx[c]) mp[c*4+1] = 1;
                    if (eot[c]) begin
                        if (mdir[m][c] == 1) mp[c*4+2] = 1;
                        else if (mdir[m][c] == 2) mp[c*4 + (m == 0 ? 3 : 2)] = 1;
                        else munk[m][c] = 1;
                    end
                end
                if (mval[m] && ready) begin
                    mcnt[m][mid[m]]--;
                    mptr[m] = (mid[m] + 1) % NS;
                end
                if (!(mval[m] && !ready)) begin
                    mval[m] = 0;
                    for (int i = 0; i < NS; i++)
                        if (!mval[m] && mcnt[m][(mptr[m] + i) % NS] > 0) begin
                            mval[m] = 1;
                            mid[m] = (mptr[m] + i) % NS;
                        end
                end
                for (int s = 0; s < NS; s++)
                    if (mp[s]) begin
                        if (mcnt[m][s] == CMAX) movf[m][s] = 1;
                        else mcnt[m][s]++;
                    end
                mevt[m] = mp;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < NB; c++) mdv[2*c +: 2] = mdir[m][c][1:0];
                chk($sformatf("model_evt%0d", m), evt_w[m], mevt[m]);
                chk($sformatf("model_valid%0d", m), valid_w[m], mval[m]);
                if (mval[m]) chk($sformatf("model_id%0d", m), id_w[m], mid[m]);
                chk($sformatf("model_dir%0d", m), dir_w[m], mdv);
                chk($sformatf("model_ovf%0d", m), ovf_w[m], movf[m]);
                chk($sformatf("model_unk%0d", m), unk_w[m], munk[m]);
            end
        end
    end
    typedef struct {
        logic [1:0] rx, tx, eot;
        logic [7:0] evt;
        logic [3:0] dir;
        logic [1:0] unk;
    } vec_t;
    vec_t tbl [8];
    int q [$];
    int hsn;
    task automatic zero_in();
        rx = 0; tx = 0; eot = 0; clr = 0;
    endtask
    task automatic do_reset();
        zero_in();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask
    task automatic collect(input int n);
        q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (valid_w[0] && ready) q.push_back(int'(id_w[0]));
        end
    endtask
    initial begin
        tbl[0] = '{2'b00, 2'b00, 2'b01, 8'h00, 4'h0, 2'b01};
        tbl[1] = '{2'b01, 2'b00, 2'b00, 8'h01, 4'h1, 2'b01};
        tbl[2] = '{2'b00, 2'b00, 2'b01, 8'h04, 4'h1, 2'b01};
        tbl[3] = '{2'b00, 2'b10, 2'b10, 8'hA0, 4'h9, 2'b01};
        tbl[4] = '{2'b11, 2'b11, 2'b00, 8'h33, 4'h9, 2'b01};
        tbl[5] = '{2'b00, 2'b01, 2'b01, 8'h0A, 4'hA, 2'b01};
        tbl[6] = '{2'b10, 2'b00, 2'b11, 8'h58, 4'h6, 2'b01};
        tbl[7] = '{2'b00, 2'b00, 2'b00, 8'h00, 4'h6, 2'b01};
        zero_in();
        rst = 1; ready = 1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_evt", evt_w[0], 0);
        chk("rst_valid", valid_w[0], 0);
        chk("rst_dir", dir_w[0], 0);
        chk("rst_ovf", ovf_w[0], 0);
        chk("rst_unk", unk_w[0], 0);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            rx = tbl[i].rx; tx = tbl[i].tx; eot = tbl[i].eot;
            @(negedge clk);
            chk($sformatf("tbl%0d_evt", i), evt_w[0], tbl[i].evt);
            chk($sformatf("tbl%0d_dir", i), dir_w[0], tbl[i].dir);
            chk($sformatf("tbl%0d_unk", i), unk_w[0], tbl[i].unk);
        end
        zero_in(); clr = 1;
        @(negedge clk);
        clr = 0;
        chk("clr_unk", unk_w[0], 0);
        // saturation with consumer stalled
        do_reset();
        ready = 0; rx = 2'b01;
        repeat (16) @(negedge clk);
        zero_in();
        chk("sat_ovf", ovf_w[0][0], 1);
        chk("sat_valid", valid_w[0], 1);
        chk("sat_id", id_w[0], 0);
        ready = 1; hsn = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_w[0]) begin
                hsn++;
                chk("sat_drain_id", id_w[0], 0);
            end
            @(negedge clk);
        end
        chk("sat_handshakes", hsn, 15);
        // round robin order from pointer 0, then from pointer 5
        do_reset();
        rx = 2'b11; eot = 2'b10;
        @(negedge clk);
        zero_in();
        chk("lat_valid_low", valid_w[0], 0);
        collect(8);
        chk("rr0_n", q.size(), 3);
        if (q.size() == 3) begin
            chk("rr0_a", q[0], 0); chk("rr0_b", q[1], 4); chk("rr0_c", q[2], 6);
        end
        rx = 2'b10;
        @(negedge clk);
        zero_in();
        collect(4);
        chk("rr_ptr_load", q.size(), 1);
        rx = 2'b11; eot = 2'b10;
        @(negedge clk);
        zero_in();
        collect(8);
        chk("rr5_n", q.size(), 3);
        if (q.size() == 3) begin
            chk("rr5_a", q[0], 6); chk("rr5_b", q[1], 0); chk("rr5_c", q[2], 4);
        end
        // EOT_SPLIT=0 folds write EOT onto the read slot
        do_reset();
        tx = 2'b01;
        @(negedge clk);
        zero_in(); eot = 2'b01;
        @(negedge clk);
        zero_in();
        chk("nosplit_eot", evt_w[1][3:2], 2'b01);
        chk("split_eot", evt_w[0][3:2], 2'b10);
        // reset while the serializer is stalled
        ready = 0; rx = 2'b01;
        @(negedge clk);
        zero_in();
        repeat (2) @(negedge clk);
        chk("stall_valid", valid_w[1], 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstmid_valid", valid_w[1], 0);
        chk("rstmid_id", id_w[1], 0);
        chk("rstmid_evt", evt_w[1], 0);
        chk("rstmid_dir", dir_w[1], 0);
        chk("rstmid_ovf", ovf_w[1], 0);
        chk("rstmid_unk", unk_w[1], 0);
        for (int c = 0; c < 600; c++) begin
            rx = NB'($urandom_range(0, 3));
            tx = NB'($urandom_range(0, 3));
            eot = NB'($urandom_range(0, 3)) & NB'($urandom_range(0, 3));
            ready = $urandom_range(0, 3) != 0;
            clr = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 99) == 0;
            @(negedge clk);
        end
        zero_in(); rst = 0; ready = 1;
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/udma_hyper_evt_router.md
Name: udma_hyper_evt_router

Overview:
- Parametrised successor of the single-channel HyperBus event logic.
- Tracks the transfer direction of each of NB_CH HyperBus channels from their uDMA RX/TX events.
- Classifies each channel's end-of-transfer into a read-EOT or write-EOT event and emits one-cycle event pulses per source.
- Also buffers all events in saturating pending counters and drains them one at a time through a valid/ready event port into the SoC event unit.

Parameters:
- NB_CH, 2: number of HyperBus channels.
- CNT_WIDTH, 4: width of each per-source pending counter.
- EOT_SPLIT, 1: 1 = classify EOT as read/write; 0 = every EOT reported on the read-EOT slot.

Ports:
- sys_clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- ch_rx_evt_i  in  NB_CH  per-channel uDMA RX-channel event pulse.
- ch_tx_evt_i  in  NB_CH  per-channel uDMA TX-channel event pulse.
- ch_eot_i  in  NB_CH  per-channel HyperBus end-of-transfer pulse.
- evt_o  out  4*NB_CH  registered event pulses; slot ch*4+{0 rx, 1 tx, 2 eot_rd, 3 eot_wr}.
- evt_valid_o  out  1  serialized event available.
- evt_id_o  out  $clog2(4*NB_CH)  slot index of the serialized event.
- evt_ready_i  in  1  consumer accepts the serialized event.
- dir_o  out  2*NB_CH  per-channel direction state (status).
- ovf_o  out  4*NB_CH  sticky pending-counter overflow.
- unk_eot_o  out  NB_CH  sticky: EOT received while direction unknown.
- clr_i  in  1  clears ovf_o and unk_eot_o.

Behaviour:
- Reset: one clock, sys_clk_i; rst_i synchronous active-high. All outputs 0, counters 0, directions DIR_UNKNOWN, RR pointer 0. rst_i wins over all other inputs, including mid-handshake; valid drops on the next edge.
- Direction FSM per channel; states DIR_UNKNOWN=0, DIR_READ=1, DIR_WRITE=2.
  - rx & !tx -> DIR_READ.
  - tx & !rx -> DIR_WRITE.
  - both set, or neither set -> hold.
  - DIR_UNKNOWN is reached only by reset.
- EOT classification uses the next-state direction, i.e. after the same-cycle rx/tx update.
  - DIR_READ -> slot 2.
  - DIR_WRITE -> slot 3, or slot 2 when EOT_SPLIT=0.
  - DIR_UNKNOWN -> no event; set unk_eot_o[ch].
- evt_o timing: input pulse at edge N, evt_o visible for exactly one cycle after edge N. No pulse merging; each cycle is evaluated independently.
- Pending counters, one per slot, updated at the same edge as evt_o:
  - +1 on that slot's classified pulse.
  - -1 on handshake (evt_valid_o & evt_ready_i) with evt_id_o == slot.
  - Increment and decrement in the same cycle -> unchanged.
  - Increment at 2^CNT_WIDTH-1 -> value holds and ovf_o[slot] is set.
- Serializer (registered):
  - While evt_valid_o & !evt_ready_i, evt_valid_o and evt_id_o are held stable.
  - Otherwise, the next edge selects round-robin among slots whose post-update counter is nonzero, starting at RR pointer.
  - After a handshake on slot k, the pointer becomes (k+1) mod 4*NB_CH.
  - Input to first possible evt_valid_o: 2 edges.
  - Back-to-back handshakes sustain 1 event/cycle.
- clr_i: clears ovf_o and unk_eot_o at the next edge. A same-cycle set wins over clear. Counters are unaffected.
- dir_o is registered: 2 bits per channel, channel 0 in the LSBs.

Decomposition:
- Shared package (udma_pkg or a hyper package):
  - direction enum hyper_dir_e.
  - slot index constants EVT_RX=0, EVT_TX=1, EVT_EOT_RD=2, EVT_EOT_WR=3, EVT_PER_CH=4.
- Sub-module udma_hyper_evt_rr_arb:
  - parametrised N-request round-robin picker with pointer input.
  - combinational, reused by the serializer.

Test Plan:
- NB_CH=2:
  - rx[0] pulse, then eot[0] 5 cycles later -> evt_o[0] then evt_o[2]; dir_o[1:0]=1; serialized ids 0, 2 in order, with ready held 1.
  - tx[1] and eot[1] in the same cycle -> evt_o[5] and evt_o[7] in the same cycle; dir_o[3:2]=2; ids 5 then 7.
- eot[0] right after reset -> no evt_o, unk_eot_o[0]=1; clr_i -> 0.
- evt_ready_i=0, 16 rx[0] pulses with CNT_WIDTH=4 -> counter saturates at 15, ovf_o[0]=1, evt_id_o held at 0. Then ready=1 -> exactly 15 handshakes, id 0.
- Pending in slots 0, 4, 6 with ready=1 -> grant order 0, 4, 6. Re-load all three after the pointer sits at 5 -> order 6, 0, 4.
- EOT_SPLIT=0:
  - tx[0] then eot[0] -> slot 2 fires, slot 3 never.
  - rst_i asserted while valid & !ready -> all outputs 0 after one edge.
